// File: rtl/if_id_stall_ctrl.sv
// IF/ID pipeline latch controller: holds on stall, squashes on flush, bubbles on
// fetch-not-ready, parks on HALT and tracks consecutive stall cycles.
module if_id_stall_ctrl #(
   parameter logic [15:0] NOP_INSTR   = 16'h0800,
   parameter logic [7:0]  STALL_LIMIT = 8'd3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        instr_valid_IF,
   input  logic [15:0] Instruction_IF,
   input  logic [15:0] PC_plus2_IF,
   output logic [15:0] Instruction_ID,
   output logic [15:0] PC_plus2_ID,
   output logic        valid_ID,
   output logic        PC_write_en,
   output logic        bubble_EX,
   output logic        halted,
   output logic [7:0]  stall_count,
   output logic        stall_err
);

   typedef enum logic [1:0] {S_RUN, S_HOLD, S_HALT} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_instr;
   logic [15:0] w_instr_nxt;
   logic [15:0] r_pc;
   logic [15:0] w_pc_nxt;
   logic        r_valid;
   logic        w_valid_nxt;
   logic [7:0]  r_count;
   logic [7:0]  w_count_nxt;
   logic        r_err;
   logic        w_halt_op;

   assign w_halt_op = r_valid && (r_instr[15:11] == 5'b00000);

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      w_state_nxt = r_state;
      w_instr_nxt = r_instr;
      w_pc_nxt    = r_pc;
      w_valid_nxt = r_valid;
      w_count_nxt = r_count;
      PC_write_en = 1'b0;
      bubble_EX   = 1'b0;

      if (r_state == S_HALT) begin
         bubble_EX = 1'b1;
         if (flush) begin
            // An older branch resolved after HALT was decoded: redirect and resume.
            w_state_nxt = S_RUN;
            w_instr_nxt = NOP_INSTR;
            w_pc_nxt    = 16'h0000;
            w_valid_nxt = 1'b0;
            w_count_nxt = 8'd0;
            PC_write_en = 1'b1;
            bubble_EX   = 1'b0;
         end
      end else if (flush) begin
         w_state_nxt = S_RUN;
         w_instr_nxt = NOP_INSTR;
         w_pc_nxt    = 16'h0000;
         w_valid_nxt = 1'b0;
         w_count_nxt = 8'd0;
         PC_write_en = 1'b1;
      end else if (stall) begin
         w_state_nxt = S_HOLD;
         bubble_EX   = 1'b1;
         w_count_nxt = (r_count == 8'hFF) ? 8'hFF : r_count + 8'd1;
      end else begin
         w_count_nxt = 8'd0;
         w_state_nxt = w_halt_op ? S_HALT : S_RUN;
         if (instr_valid_IF) begin
            w_instr_nxt = Instruction_IF;
            w_pc_nxt    = PC_plus2_IF;
            w_valid_nxt = 1'b1;
            PC_write_en = 1'b1;
         end else begin
            w_instr_nxt = NOP_INSTR;
            w_pc_nxt    = 16'h0000;
            w_valid_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_RUN;
         r_instr <= NOP_INSTR;
         r_pc    <= 16'h0000;
         r_valid <= 1'b0;
         r_count <= 8'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_instr <= w_instr_nxt;
         r_pc    <= w_pc_nxt;
         r_valid <= w_valid_nxt;
         r_count <= w_count_nxt;
         r_err   <= (w_count_nxt >= STALL_LIMIT);
      end
   end

   assign Instruction_ID = r_instr;
   assign PC_plus2_ID    = r_pc;
   assign valid_ID       = r_valid;
   assign halted         = (r_state == S_HALT);
   assign stall_count    = r_count;
   assign stall_err      = r_err;

endmodule

// File: tb/tb_if_id_stall_ctrl.sv
// Directed bench for if_id_stall_ctrl: vector table for single-cycle behaviour,
// hand-written sequences for HALT and stall-count saturation.
module tb_if_id_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        flush;
   logic        instr_valid_IF;
   logic [15:0] Instruction_IF;
   logic [15:0] PC_plus2_IF;
   logic [15:0] Instruction_ID;
   logic [15:0] PC_plus2_ID;
   logic        valid_ID;
   logic        PC_write_en;
   logic        bubble_EX;
   logic        halted;
   logic [7:0]  stall_count;
   logic        stall_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   if_id_stall_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .flush          (flush),
      .instr_valid_IF (instr_valid_IF),
      .Instruction_IF (Instruction_IF),
      .PC_plus2_IF    (PC_plus2_IF),
      .Instruction_ID (Instruction_ID),
      .PC_plus2_ID    (PC_plus2_ID),
      .valid_ID       (valid_ID),
      .PC_write_en    (PC_write_en),
      .bubble_EX      (bubble_EX),
      .halted         (halted),
      .stall_count    (stall_count),
      .stall_err      (stall_err)
   );

   typedef struct {
      logic        rst, stall, flush, iv;
      logic [15:0] instr, pc;
      logic        chk_comb, pcwe, bub;
      logic        chk_pc;
      logic [15:0] e_instr, e_pc;
      logic        e_valid, e_halt;
      logic [7:0]  e_cnt;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic r, s, f, iv, input logic [15:0] in, pc,
      input logic cc, pcwe, bub, cp, input logic [15:0] ei, ep,
      input logic ev, eh, input logic [7:0] ec, input logic ee);
      vec_t v;
      v.rst = r; v.stall = s; v.flush = f; v.iv = iv; v.instr = in; v.pc = pc;
      v.chk_comb = cc; v.pcwe = pcwe; v.bub = bub; v.chk_pc = cp;
      v.e_instr = ei; v.e_pc = ep; v.e_valid = ev; v.e_halt = eh; v.e_cnt = ec; v.e_err = ee;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, s, f, iv, input logic [15:0] in, pc);
      rst = r; stall = s; flush = f; instr_valid_IF = iv; Instruction_IF = in; PC_plus2_IF = pc;
   endtask

   // Advance one clock and land 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_regs(input string tag, input logic [15:0] ei, input logic ev,
                             input logic eh, input logic [7:0] ec, input logic ee);
      check({tag, " instr"},  Instruction_ID, ei);
      check({tag, " valid"},  {15'd0, valid_ID}, {15'd0, ev});
      check({tag, " halted"}, {15'd0, halted}, {15'd0, eh});
      check({tag, " count"},  {8'd0, stall_count}, {8'd0, ec});
      check({tag, " err"},    {15'd0, stall_err}, {15'd0, ee});
   endtask

   initial begin
      // Reset mid-stall
      vecs.push_back(mk(1,0,0,1,16'h1111,16'h0002, 0,0,0, 1,16'h0800,16'h0000,0,0,8'd0,0));
      vecs.push_back(mk(0,1,0,1,16'h1111,16'h0002, 1,0,1, 1,16'h0800,16'h0000,0,0,8'd1,0));
      vecs.push_back(mk(0,1,0,1,16'h1111,16'h0002, 1,0,1, 1,16'h0800,16'h0000,0,0,8'd2,0));
      vecs.push_back(mk(1,1,0,1,16'h1111,16'h0002, 0,0,0, 1,16'h0800,16'h0000,0,0,8'd0,0));
      // Single stall
      vecs.push_back(mk(0,0,0,1,16'hC123,16'h0004, 1,1,0, 1,16'hC123,16'h0004,1,0,8'd0,0));
      vecs.push_back(mk(0,1,0,1,16'hD456,16'h0006, 1,0,1, 1,16'hC123,16'h0004,1,0,8'd1,0));
      vecs.push_back(mk(0,0,0,1,16'hD456,16'h0006, 1,1,0, 1,16'hD456,16'h0006,1,0,8'd0,0));
      // Runaway stall
      vecs.push_back(mk(0,1,0,1,16'hE000,16'h0008, 1,0,1, 1,16'hD456,16'h0006,1,0,8'd1,0));
      vecs.push_back(mk(0,1,0,1,16'hE000,16'h0008, 1,0,1, 1,16'hD456,16'h0006,1,0,8'd2,0));
      vecs.push_back(mk(0,1,0,1,16'hE000,16'h0008, 1,0,1, 1,16'hD456,16'h0006,1,0,8'd3,1));
      vecs.push_back(mk(0,0,0,1,16'hE000,16'h0008, 1,1,0, 1,16'hE000,16'h0008,1,0,8'd0,0));
      // Flush/stall collision
      vecs.push_back(mk(0,1,1,1,16'hF000,16'h000A, 1,1,0, 0,16'h0800,16'h0000,0,0,8'd0,0));
      // Fetch not ready, then recovery
      vecs.push_back(mk(0,0,0,0,16'h7777,16'h000A, 1,0,0, 0,16'h0800,16'h0000,0,0,8'd0,0));
      vecs.push_back(mk(0,0,0,0,16'h7777,16'h000A, 1,0,0, 0,16'h0800,16'h0000,0,0,8'd0,0));
      vecs.push_back(mk(0,0,0,1,16'h4000,16'h000A, 1,1,0, 1,16'h4000,16'h000A,1,0,8'd0,0));
      // Flush clears an erroring stall run
      vecs.push_back(mk(0,1,0,1,16'h5000,16'h000C, 1,0,1, 1,16'h4000,16'h000A,1,0,8'd1,0));
      vecs.push_back(mk(0,1,0,1,16'h5000,16'h000C, 1,0,1, 1,16'h4000,16'h000A,1,0,8'd2,0));
      vecs.push_back(mk(0,1,0,1,16'h5000,16'h000C, 1,0,1, 1,16'h4000,16'h000A,1,0,8'd3,1));
      vecs.push_back(mk(0,1,1,1,16'h5000,16'h000C, 1,1,0, 0,16'h0800,16'h0000,0,0,8'd0,0));

      drive(1, 0, 0, 1, 16'h1111, 16'h0002);
      tick();
      tick();

      foreach (vecs[i]) begin
         string tag;
         tag = $sformatf("v%0d", i);
         drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].iv, vecs[i].instr, vecs[i].pc);
         #1;
         if (vecs[i].chk_comb) begin
            check({tag, " pcwe"},   {15'd0, PC_write_en}, {15'd0, vecs[i].pcwe});
            check({tag, " bubble"}, {15'd0, bubble_EX},   {15'd0, vecs[i].bub});
         end
         tick();
         check_regs(tag, vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_halt, vecs[i].e_cnt, vecs[i].e_err);
         if (vecs[i].chk_pc) check({tag, " pc"}, PC_plus2_ID, vecs[i].e_pc);
      end

      // HALT: stall delays entry, then HALT parks the front end until flush.
      drive(0, 0, 0, 1, 16'h0000, 16'h0010);
      tick();
      check_regs("h_load", 16'h0000, 1, 0, 8'd0, 0);
      drive(0, 1, 0, 1, 16'h1234, 16'h0012);
      tick();
      check_regs("h_stall", 16'h0000, 1, 0, 8'd1, 0);
      drive(0, 0, 0, 1, 16'h1234, 16'h0012);
      #1;
      check("h_enter pcwe", {15'd0, PC_write_en}, 16'd1);
      tick();
      check_regs("h_enter", 16'h1234, 1, 1, 8'd0, 0);
      check("h_enter pc", PC_plus2_ID, 16'h0012);
      for (int k = 0; k < 3; k++) begin
         drive(0, k[0], 0, k[1], 16'h5678 + 16'(k), 16'h0020);
         #1;
         check($sformatf("h_park%0d pcwe", k), {15'd0, PC_write_en}, 16'd0);
         check($sformatf("h_park%0d bubble", k), {15'd0, bubble_EX}, 16'd1);
         tick();
         check_regs($sformatf("h_park%0d", k), 16'h1234, 1, 1, 8'd0, 0);
      end
      drive(0, 0, 1, 1, 16'h9999, 16'h0030);
      tick();
      check_regs("h_flush", 16'h0800, 0, 0, 8'd0, 0);
      drive(0, 0, 0, 1, 16'h9000, 16'h0032);
      #1;
      check("h_resume pcwe", {15'd0, PC_write_en}, 16'd1);
      tick();
      check_regs("h_resume", 16'h9000, 1, 0, 8'd0, 0);

      // Stall count saturation at 8'hFF
      drive(0, 1, 0, 1, 16'hA000, 16'h0040);
      for (int k = 0; k < 254; k++) tick();
      check_regs("sat_fe", 16'h9000, 1, 0, 8'hFE, 1);
      tick();
      check_regs("sat_ff", 16'h9000, 1, 0, 8'hFF, 1);
      tick();
      check_regs("sat_hold", 16'h9000, 1, 0, 8'hFF, 1);
      drive(0, 0, 0, 1, 16'hA000, 16'h0040);
      tick();
      check_regs("sat_clear", 16'hA000, 1, 0, 8'd0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
